// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   dmem_state_t   : responder FSM state encoding (IDLE, WAIT, RESP)
//   BYTES_PER_WORD : bytes in one stored word
//   WAIT_W         : width of the wait-state counter
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WAIT_W         = 4;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x WIDTH word storage, asynchronous read, synchronous
// byte-enabled write. Contents are not reset.
// Ports:
//   clk   : clock, rising edge
//   we    : write strobe
//   be    : byte enables, bit i writes byte i
//   waddr : word index for writes
//   wdata : write data
//   raddr : word index for reads
//   rdata : read data (combinational)
module dmem_array #(
    parameter  int unsigned DEPTH = 64,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [WIDTH/8-1:0] be,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [AW-1:0]      raddr,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < WIDTH/8; i++) begin
                if (be[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core's load/store data-memory port.
// Accepts one word-aligned request at a time, inserts WAIT_CYCLES wait
// states, then holds the result on the response channel until taken.
// Optional macro DMEM_ACCESS_CNT_EN adds rd_count / wr_count outputs that
// count successful reads and writes.
// Ports:
//   clk, reset            : clock (rising edge), async active-low reset
//   req_valid / req_ready : request handshake
//   req_we, req_addr      : 1 = write; byte address
//   req_wdata, req_be     : write data and byte enables
//   resp_valid/resp_ready : response handshake
//   resp_rdata, resp_err  : read data (0 for writes/errors); access error
//   rd_count, wr_count    : (DMEM_ACCESS_CNT_EN only) access counters
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [WIDTH/8-1:0] req_be,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_rdata,
    output logic               resp_err
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

    dmem_state_t        state;
    logic [WAIT_W-1:0]  cnt;
    logic               l_we;
    logic [31:0]        l_addr;
    logic [WIDTH-1:0]   l_wdata;
    logic [WIDTH/8-1:0] l_be;

    logic               accept;
    logic               commit;
    logic               c_we;
    logic [31:0]        c_addr;
    logic [WIDTH-1:0]   c_wdata;
    logic [WIDTH/8-1:0] c_be;
    logic               c_err;
    logic [AW-1:0]      c_idx;
    logic [WIDTH-1:0]   arr_rdata;

    assign accept = req_valid & req_ready;

    // With zero wait states the commit edge is the accept edge itself, so the
    // commit operands come straight from the request port instead of the
    // latched copy.
    always_comb begin
        commit  = 1'b0;
        c_we    = l_we;
        c_addr  = l_addr;
        c_wdata = l_wdata;
        c_be    = l_be;
        if (state == IDLE) begin
            commit  = accept && (WAIT_CYCLES == 0);
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
        end else if (state == WAIT) begin
            commit = (cnt == '0);
        end
    end

    assign c_err = (c_addr[1:0] != 2'b00) || (c_addr[31:AW+2] != '0);
    assign c_idx = c_addr[AW+1:2];

    dmem_array #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (commit & c_we & ~c_err),
        .be    (c_be),
        .waddr (c_idx),
        .wdata (c_wdata),
        .raddr (c_idx),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            l_we       <= 1'b0;
            l_addr     <= '0;
            l_wdata    <= '0;
            l_be       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        l_we      <= req_we;
                        l_addr    <= req_addr;
                        l_wdata   <= req_wdata;
                        l_be      <= req_be;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            cnt   <= WAIT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase

            if (commit) begin
                resp_rdata <= (c_we || c_err) ? '0 : arr_rdata;
                resp_err   <= c_err;
            end
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (commit && !c_err) begin
            if (c_we) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    // Instance with WAIT_CYCLES = 2
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // Instance with WAIT_CYCLES = 0
    logic        z_req_valid = 1'b0;
    logic        z_req_ready;
    logic        z_req_we = 1'b0;
    logic [31:0] z_req_addr = '0;
    logic [31:0] z_req_wdata = '0;
    logic [3:0]  z_req_be = '0;
    logic        z_resp_valid;
    logic        z_resp_ready = 1'b0;
    logic [31:0] z_resp_rdata;
    logic        z_resp_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH       (64),
        .WIDTH       (32),
        .WAIT_CYCLES (2)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    dmem_responder #(
        .DEPTH       (64),
        .WIDTH       (32),
        .WAIT_CYCLES (0)
    ) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_we     (z_req_we),
        .req_addr   (z_req_addr),
        .req_wdata  (z_req_wdata),
        .req_be     (z_req_be),
        .resp_valid (z_resp_valid),
        .resp_ready (z_resp_ready),
        .resp_rdata (z_resp_rdata),
        .resp_err   (z_resp_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction on the WAIT_CYCLES=2 instance. lat counts rising
    // edges from the accept edge (inclusive) until resp_valid is seen.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rd, output logic er,
                          output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          guard;

        vecs.push_back('{1'b1, 32'h10,       32'hDEADBEEF, 4'b1111, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10,       32'h0,        4'b0000, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h20,       32'h11223344, 4'b1111, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h20,       32'hAABBCCDD, 4'b0101, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h20,       32'h0,        4'b1111, 32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b0, 32'h22,       32'h0,        4'b1111, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h00,       32'hCAFEF00D, 4'b1111, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h100,      32'h12345678, 4'b1111, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h00,       32'h0,        4'b0000, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b1, 32'h20,       32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h20,       32'h0,        4'b0000, 32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b1, 32'hFC,       32'h0BADCAFE, 4'b1111, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'hFC,       32'h0,        4'b1010, 32'h0BADCAFE, 1'b0});
        vecs.push_back('{1'b0, 32'h80000000, 32'h0,        4'b0000, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h08,       32'h77777777, 4'b1111, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h0E,       32'h55555555, 4'b1111, 32'h0,        1'b1});

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst req_ready",   32'(req_ready),   32'd1);
        check("rst resp_valid",  32'(resp_valid),  32'd0);
        check("rst resp_rdata",  resp_rdata,       32'h0);
        check("rst resp_err",    32'(resp_err),    32'd0);
        check("rst z_req_ready", 32'(z_req_ready), 32'd1);

        // Table-driven transactions
        for (int i = 0; i < vecs.size(); i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
            check($sformatf("v%0d rdata", i),   rd,          vecs[i].exp_rdata);
            check($sformatf("v%0d err", i),     32'(er),     32'(vecs[i].exp_err));
            check($sformatf("v%0d latency", i), 32'(lat),    32'd3);
        end

        // Backpressure: response held for 5 cycles with a competing request
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_be    = 4'b0000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        req_be    = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d resp_valid", k), 32'(resp_valid), 32'd1);
            check($sformatf("bp%0d rdata", k),      resp_rdata,      32'hDEADBEEF);
            check($sformatf("bp%0d err", k),        32'(resp_err),   32'd0);
            check($sformatf("bp%0d req_ready", k),  32'(req_ready),  32'd0);
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("bp release resp_valid", 32'(resp_valid), 32'd0);
        check("bp release req_ready",  32'(req_ready),  32'd1);
        do_txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        check("bp intruder dropped", rd, 32'hDEADBEEF);

        // Reset during WAIT drops an uncommitted write
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h08;
        req_wdata = 32'h00000005;
        req_be    = 4'b1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("midrst in WAIT req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("midrst async req_ready",  32'(req_ready),  32'd1);
        check("midrst async resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst post req_ready",  32'(req_ready),  32'd1);
        check("midrst post resp_valid", 32'(resp_valid), 32'd0);
        do_txn(1'b0, 32'h08, 32'h0, 4'b0000, rd, er, lat);
        check("midrst word kept", rd, 32'h77777777);

        // WAIT_CYCLES=0: back-to-back writes every 2 cycles
        @(negedge clk);
        z_req_valid  = 1'b1;
        z_req_we     = 1'b1;
        z_req_addr   = 32'h04;
        z_req_wdata  = 32'h000000A5;
        z_req_be     = 4'b1111;
        z_resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("z c%0d req_ready", c),  32'(z_req_ready),  (c % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("z c%0d resp_valid", c), 32'(z_resp_valid), (c % 2 == 1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        z_req_we   = 1'b0;
        z_req_addr = 32'h04;
        @(posedge clk);
        #1;
        z_req_valid = 1'b0;
        check("z read latency", 32'(z_resp_valid), 32'd1);
        check("z read rdata",   z_resp_rdata,      32'h000000A5);
        check("z read err",     32'(z_resp_err),   32'd0);
        @(posedge clk);
        #1;
        check("z after handshake", 32'(z_resp_valid), 32'd0);
        z_resp_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
